// File: rtl/ads_g729_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ads_g729_pkg
//  Description : Shared definitions for the ADS speech front-end. Holds the
//                frame sequencer state encoding and the G.729 frame geometry
//                (80-sample frames at 8 kHz, split into two 40-sample
//                subframes).
//  Revision    : 1.0 - initial release
// ============================================================================
package ads_g729_pkg;

    localparam int G729_FRAME_LEN    = 80;
    localparam int G729_SUBFRAME_LEN = 40;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_FILL = 3'd1,
        READ      = 3'd2,
        FLUSH     = 3'd3,
        HANDOFF   = 3'd4
    } fsq_state_t;

endpackage
`default_nettype wire

// File: rtl/ads_frame_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : ads_frame_sequencer_if
//  Description : Bundle of every frame-sequencer signal except clock and
//                reset: clock enable, configuration, audio FIFO status/data,
//                frame-buffer write port and LPC hand-off.
//                  master : the sequencer (drives fsq_*)
//                  slave  : the surrounding system (FIFO, buffer, LPC stage)
//  Revision    : 1.0 - initial release
// ============================================================================
interface ads_frame_sequencer_if #(
    parameter int RAM_ADDR_WIDTH  = 10,
    parameter int RAM_DATA_WIDTH  = 32,
    parameter int BUF_ADDR_WIDTH  = 7,
    parameter int FRAME_CNT_WIDTH = 16
);
    // control
    logic                       sys_ce;
    logic                       cfg_enable;
    // audio sample FIFO (show-ahead read port)
    logic [RAM_ADDR_WIDTH-1:0]  aff_data_count;
    logic                       aff_data_empty;
    logic                       aff_data_full;
    logic [RAM_DATA_WIDTH-1:0]  aff_read_data;
    logic                       fsq_rd_en;
    // LPC frame buffer write port
    logic                       fsq_buf_wr_en;
    logic [BUF_ADDR_WIDTH-1:0]  fsq_buf_wr_addr;
    logic [RAM_DATA_WIDTH-1:0]  fsq_buf_wr_data;
    // LPC hand-off and status
    logic                       fsq_frame_valid;
    logic                       lpc_frame_done;
    logic [FRAME_CNT_WIDTH-1:0] fsq_frame_num;
    logic                       fsq_ovf_err;

    modport master (
        input  sys_ce, cfg_enable,
        input  aff_data_count, aff_data_empty, aff_data_full, aff_read_data,
        input  lpc_frame_done,
        output fsq_rd_en,
        output fsq_buf_wr_en, fsq_buf_wr_addr, fsq_buf_wr_data,
        output fsq_frame_valid, fsq_frame_num, fsq_ovf_err
    );

    modport slave (
        output sys_ce, cfg_enable,
        output aff_data_count, aff_data_empty, aff_data_full, aff_read_data,
        output lpc_frame_done,
        input  fsq_rd_en,
        input  fsq_buf_wr_en, fsq_buf_wr_addr, fsq_buf_wr_data,
        input  fsq_frame_valid, fsq_frame_num, fsq_ovf_err
    );

endinterface
`default_nettype wire

// File: rtl/ads_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ads_frame_sequencer
//  Description : Moves one FRAME_LEN-sample frame at a time from the audio
//                sample FIFO into the LPC frame buffer, then presents it to
//                the LPC stage with a valid/done handshake.
//  Ports       : sys_clk   - system clock
//                sys_rst_n - synchronous active-low reset
//                bus       - ads_frame_sequencer_if.master
//                  sys_ce          clock enable (0 = hold, strobes forced 0)
//                  cfg_enable      sequencer enable
//                  aff_*           FIFO fill count / empty / full / head word
//                  fsq_rd_en       FIFO read enable (combinational)
//                  fsq_buf_wr_*    frame buffer write port (1-cycle after read)
//                  fsq_frame_valid complete frame present in the buffer
//                  lpc_frame_done  LPC stage has released the buffer
//                  fsq_frame_num   frames handed off (wrapping)
//                  fsq_ovf_err     sticky FIFO-overflow flag
//  Revision    : 1.0 - initial release
// ============================================================================
module ads_frame_sequencer
    import ads_g729_pkg::*;
#(
    parameter int RAM_ADDR_WIDTH  = 10,
    parameter int RAM_DATA_WIDTH  = 32,
    parameter int FRAME_LEN       = G729_FRAME_LEN,
    parameter int BUF_ADDR_WIDTH  = 7,
    parameter int FRAME_CNT_WIDTH = 16
) (
    input  wire logic              sys_clk,
    input  wire logic              sys_rst_n,
    ads_frame_sequencer_if.master  bus
);

    localparam logic [BUF_ADDR_WIDTH-1:0] c_LAST_IDX      = BUF_ADDR_WIDTH'(FRAME_LEN - 1);
    localparam logic [RAM_ADDR_WIDTH-1:0] c_FRAME_LEN_CNT = RAM_ADDR_WIDTH'(FRAME_LEN);

    fsq_state_t                 r_state;
    logic [BUF_ADDR_WIDTH-1:0]  r_rd_idx;
    logic                       r_buf_wr_en;
    logic [BUF_ADDR_WIDTH-1:0]  r_buf_wr_addr;
    logic [RAM_DATA_WIDTH-1:0]  r_buf_wr_data;
    logic                       r_frame_valid;
    logic [FRAME_CNT_WIDTH-1:0] r_frame_num;
    logic                       r_ovf_err;
    logic                       w_rd_en;

    // Show-ahead FIFO: the head word is consumed in the same cycle rd_en is
    // high, so the read strobe must be combinational. An empty FIFO simply
    // stalls the burst.
    assign w_rd_en = (r_state == READ) && !bus.aff_data_empty && bus.sys_ce;

    assign bus.fsq_rd_en       = w_rd_en;
    // The write strobe register holds through a clock-enable gap; masking it
    // here keeps the buffer write from being seen more than once.
    assign bus.fsq_buf_wr_en   = r_buf_wr_en && bus.sys_ce;
    assign bus.fsq_buf_wr_addr = r_buf_wr_addr;
    assign bus.fsq_buf_wr_data = r_buf_wr_data;
    assign bus.fsq_frame_valid = r_frame_valid;
    assign bus.fsq_frame_num   = r_frame_num;
    assign bus.fsq_ovf_err     = r_ovf_err;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            // Also abandons any partially transferred frame.
            r_state       <= IDLE;
            r_rd_idx      <= '0;
            r_buf_wr_en   <= 1'b0;
            r_buf_wr_addr <= '0;
            r_buf_wr_data <= '0;
            r_frame_valid <= 1'b0;
            r_frame_num   <= '0;
            r_ovf_err     <= 1'b0;
        end else if (bus.sys_ce) begin
            // Buffer write stage: one cycle behind the FIFO read.
            r_buf_wr_en <= w_rd_en;
            if (w_rd_en) begin
                r_buf_wr_addr <= r_rd_idx;
                r_buf_wr_data <= bus.aff_read_data;
            end

            // Full while enabled means the LPC stage is not keeping up.
            // Sequencing is unaffected; the flag only reports it.
            if (bus.aff_data_full && bus.cfg_enable) begin
                r_ovf_err <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (bus.cfg_enable) begin
                        r_state <= WAIT_FILL;
                    end else begin
                        r_ovf_err <= 1'b0;
                    end
                end

                WAIT_FILL: begin
                    if (!bus.cfg_enable) begin
                        r_state <= IDLE;
                    end else if (bus.aff_data_count >= c_FRAME_LEN_CNT) begin
                        r_state <= READ;
                    end
                end

                // Enable is deliberately not looked at here: a started
                // frame always completes.
                READ: begin
                    if (w_rd_en) begin
                        if (r_rd_idx == c_LAST_IDX) begin
                            r_rd_idx <= '0;
                            r_state  <= FLUSH;
                        end else begin
                            r_rd_idx <= r_rd_idx + 1'b1;
                        end
                    end
                end

                // Last buffer write is on the bus this cycle.
                FLUSH: begin
                    r_frame_valid <= 1'b1;
                    r_state       <= HANDOFF;
                end

                HANDOFF: begin
                    if (bus.lpc_frame_done) begin
                        r_frame_valid <= 1'b0;
                        r_frame_num   <= r_frame_num + 1'b1;
                        r_state       <= bus.cfg_enable ? WAIT_FILL : IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/ads_frame_sequencer.md
Name: ads_frame_sequencer

Overview:
- Controller between the audio sample FIFO and the LPC analysis stage (autocorrelation / Levinson-Durbin).
- Waits until the FIFO holds one full frame of FRAME_LEN samples, then bursts the frame out of the FIFO into the LPC frame buffer.
- Hands the frame to the LPC stage with a valid/done handshake and counts frames.
- Flags FIFO overflow, which means the LPC stage is too slow.

Parameters:
- RAM_ADDR_WIDTH, 10: FIFO address/count width.
- RAM_DATA_WIDTH, 32: sample width.
- FRAME_LEN, 80: samples per frame (10 ms at 8 kHz); legal range 1..2**BUF_ADDR_WIDTH.
- BUF_ADDR_WIDTH, 7: frame buffer address width.
- FRAME_CNT_WIDTH, 16: frame counter width.

Ports:
- sys_clk, in, 1: system clock.
- sys_rst_n, in, 1: reset. Synchronous, active-low.
- sys_ce, in, 1: clock enable. Low means every register holds and all strobes are forced to 0.
- cfg_enable, in, 1: sequencer enable.
- aff_data_count, in, RAM_ADDR_WIDTH: FIFO fill count.
- aff_data_empty, in, 1: FIFO empty.
- aff_data_full, in, 1: FIFO full.
- aff_read_data, in, RAM_DATA_WIDTH: FIFO head word. Show-ahead: valid whenever not empty and consumed on the rd_en cycle.
- fsq_rd_en, out, 1: FIFO read enable, drives ldb_read_en.
- fsq_buf_wr_en, out, 1: frame buffer write strobe.
- fsq_buf_wr_addr, out, BUF_ADDR_WIDTH: frame buffer write address.
- fsq_buf_wr_data, out, RAM_DATA_WIDTH: frame buffer write data.
- fsq_frame_valid, out, 1: complete frame is in the buffer.
- lpc_frame_done, in, 1: LPC stage has finished with the buffer (1-cycle pulse).
- fsq_frame_num, out, FRAME_CNT_WIDTH: number of frames handed off.
- fsq_ovf_err, out, 1: sticky FIFO-overflow flag.

Behaviour:
- Reset (sys_rst_n=0 at a clock edge): state IDLE, all outputs 0, counters 0. This applies from any state, including mid-burst; a partially written frame is discarded.
- FSM states: IDLE, WAIT_FILL, READ, FLUSH, HANDOFF.
- IDLE:
  - cfg_enable=1 moves to WAIT_FILL.
  - cfg_enable=0 also clears fsq_ovf_err.
- WAIT_FILL:
  - Moves to READ when aff_data_count >= FRAME_LEN.
  - Moves to IDLE if cfg_enable=0.
- READ:
  - fsq_rd_en = !aff_data_empty && sys_ce. This is combinational and is 0 in every other state.
  - Each read increments rd_idx.
  - When the read with rd_idx = FRAME_LEN-1 occurs, rd_idx is cleared and the FSM moves to FLUSH.
  - If the FIFO goes empty mid-burst, rd_en stalls with no error.
  - cfg_enable dropping mid-burst does not abort; the frame completes.
- Buffer write path, registered with 1-cycle latency:
  - fsq_buf_wr_en <= fsq_rd_en.
  - fsq_buf_wr_addr <= rd_idx.
  - fsq_buf_wr_data <= aff_read_data.
  - Addresses run 0..FRAME_LEN-1 in order with no gaps.
- FLUSH: one cycle for the last buffer write, then to HANDOFF. fsq_frame_valid rises on entry to HANDOFF, so it is high one cycle after the last fsq_buf_wr_en.
- HANDOFF:
  - fsq_frame_valid is held high until lpc_frame_done is sampled high.
  - Next cycle: frame_valid=0, fsq_frame_num increments (wraps at 2**FRAME_CNT_WIDTH), and the FSM goes to WAIT_FILL if cfg_enable=1, otherwise IDLE.
  - lpc_frame_done is honoured on the same cycle frame_valid first goes high.
  - lpc_frame_done in any other state is ignored.
- Back-to-back frames: if the FIFO already holds >= FRAME_LEN on return to WAIT_FILL, READ starts the following cycle.
- Overflow:
  - fsq_ovf_err sets on any cycle with aff_data_full=1 while cfg_enable=1.
  - It stays set until IDLE with cfg_enable=0, or reset.
  - Full does not alter sequencing.
- sys_ce=0: state, counters and outputs freeze; fsq_rd_en=0 and fsq_buf_wr_en=0.
- Widths: rd_idx is BUF_ADDR_WIDTH wide. The count compare is unsigned, with FRAME_LEN zero-extended to RAM_ADDR_WIDTH.

Decomposition:
- Shared package ads_g729_pkg holds:
  - FSM state enum (fsq_state_t): IDLE, WAIT_FILL, READ, FLUSH, HANDOFF.
  - Constants G729_FRAME_LEN=80 and G729_SUBFRAME_LEN=40.
- No sub-module: a single FSM with a counter and a write-back register stage.

Test Plan:
- Reset/idle: hold sys_rst_n=0 for 3 cycles, release with cfg_enable=0 → all outputs 0, FSM stays IDLE, no rd_en.
- Single frame: cfg_enable=1, FIFO preloaded with 80 words 0..79, lpc_frame_done returned 5 cycles after frame_valid →
  - exactly 80 contiguous rd_en;
  - buf_wr addr/data 0..79, each 1 cycle after its rd_en;
  - frame_valid 1 cycle after the last write, held until done;
  - frame_num=1.
- Threshold: FIFO count 79 → no rd_en for 20 cycles; the 80th sample arrives → READ starts the next cycle.
- Stall: FIFO starts at 80 with reads racing writes so empty asserts mid-burst at sample 40 → rd_en drops while empty; the frame still completes with 80 writes in order.
- Back-to-back with disable: FIFO at 200, done pulsed the same cycle frame_valid rises, cfg_enable dropped during the second READ → second frame completes, frame_num=2, then IDLE with no third burst.
- Overflow and mid-burst reset:
  - aff_data_full pulsed 1 cycle → fsq_ovf_err stays 1 through frames and clears only after cfg_enable=0 in IDLE.
  - sys_rst_n=0 at sample 30 → outputs 0 next edge; a fresh frame restarts at address 0.
